// File: rtl/gbuff_feeder.sv
// gbuff_feeder: streams a run of consecutive global-buffer words into the
// systolic array, one byte lane per PE row, with zero padding on idle lanes
// and a one-cycle done pulse at the end of the run.
// Build option: define FEEDER_SKEW_EN to delay lane i by i extra cycles
// (diagonal skew). Without it, all lanes of a word leave together.

// One PE-row lane: an entry register followed by DEPTH-1 skew registers.
// Invalid words are zeroed on entry, so padding stays zero down the pipe.
module gbuff_feeder_lane #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_vld,
  output logic [DATA_SIZE-1:0] o_data
);
  logic [DEPTH-1:0]                r_vld_pipe;
  logic [DEPTH-1:0][DATA_SIZE-1:0] r_data_pipe;

  // shift valid and data together; stage 0 is the lane entry stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe  <= '0;
      r_data_pipe <= '0;
    end else begin
      r_vld_pipe[0]  <= i_vld;
      r_data_pipe[0] <= i_vld ? i_data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld_pipe[k]  <= r_vld_pipe[k-1];
        r_data_pipe[k] <= r_data_pipe[k-1];
      end
    end
  end

  assign o_vld  = r_vld_pipe[DEPTH-1];
  assign o_data = r_data_pipe[DEPTH-1];
endmodule

module gbuff_feeder #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_SIZE  = 8,
  parameter int WORD_SIZE  = 32,
  parameter int INDX_SIZE  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [INDX_SIZE-1:0]           base_addr,
  input  logic [7:0]                     k_len,
  output logic                           gbuff_wr_en,
  output logic [INDX_SIZE-1:0]           gbuff_index,
  input  logic [WORD_SIZE-1:0]           gbuff_data,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0] row_data,
  output logic [ARRAY_SIZE-1:0]          row_valid,
  output logic                           busy,
  output logic                           done
);
`ifdef FEEDER_SKEW_EN
  localparam bit SKEW_EN = 1'b1;
`else
  localparam bit SKEW_EN = 1'b0;
`endif

  // DRAIN covers the read-valid stage, the lane entry stage and, with skew,
  // the ARRAY_SIZE-1 extra registers on the slowest lane.
  localparam int DRAIN_CYC = SKEW_EN ? ARRAY_SIZE + 1 : 2;
  localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_nxt;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [INDX_SIZE-1:0]  r_index;
  logic [DCNT_W-1:0]     r_dcnt;
  logic                  r_zhold;
  logic                  r_rvld;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_done;

  assign w_last = (r_cnt == r_len - 8'd1);

  // A zero-length job spends one settling cycle in DONE with done low, so
  // its pulse lands two cycles after start like any other short job.
  assign w_done = (r_state == S_DONE) && !r_zhold;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // next-state logic; start is only looked at in IDLE
  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_nxt    = (k_len == 8'd0) ? S_DONE : S_READ;
        end
      end
      S_READ:  if (w_last)               w_nxt = S_DRAIN;
      S_DRAIN: if (r_dcnt == DRAIN_LAST) w_nxt = S_DONE;
      S_DONE:  if (!r_zhold)             w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // job latch, word counter and read index; index wraps at 2^INDX_SIZE and
  // holds its last value outside READ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len   <= '0;
      r_cnt   <= '0;
      r_index <= '0;
      r_zhold <= 1'b0;
    end else if (w_accept) begin
      r_len   <= k_len;
      r_cnt   <= '0;
      r_zhold <= (k_len == 8'd0);
      if (k_len != 8'd0) r_index <= base_addr;
    end else begin
      if (r_state == S_READ && !w_last) begin
        r_cnt   <= r_cnt + 8'd1;
        r_index <= r_index + INDX_SIZE'(1);
      end
      if (r_state == S_DONE) r_zhold <= 1'b0;
    end
  end

  // drain wait counter, idle at zero outside DRAIN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_dcnt <= '0;
    else if (r_state == S_DRAIN)  r_dcnt <= r_dcnt + DCNT_W'(1);
    else                          r_dcnt <= '0;
  end

  // read-valid pipe: marks the cycle the buffer returns a requested word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rvld <= 1'b0;
    else      r_rvld <= (r_state == S_READ);
  end

  // per-row lanes; lane i is i cycles deeper when skew is on
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    gbuff_feeder_lane #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (SKEW_EN ? gi + 1 : 1)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_vld  (r_rvld),
      .i_data (gbuff_data[DATA_SIZE*gi +: DATA_SIZE]),
      .o_vld  (row_valid[gi]),
      .o_data (row_data[DATA_SIZE*gi +: DATA_SIZE])
    );
  end

  assign gbuff_wr_en = 1'b0;
  assign gbuff_index = r_index;
  assign busy        = (r_state != S_IDLE);
  assign done        = w_done;
endmodule

// File: tb/tb_gbuff_feeder.sv
// Bench for gbuff_feeder: table of runs plus hand-written reset and
// start-collision sequences; a cycle-accurate scoreboard checks every row,
// read index and done pulse. Follows FEEDER_SKEW_EN like the design.
module tb_gbuff_feeder;
  localparam int A  = 4;
  localparam int D  = 8;
  localparam int W  = 32;
  localparam int IW = 8;
`ifdef FEEDER_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [IW-1:0] base_addr;
  logic [7:0]    k_len;
  logic          gbuff_wr_en;
  logic [IW-1:0] gbuff_index;
  logic [W-1:0]  gbuff_data;
  logic [A*D-1:0] row_data;
  logic [A-1:0]  row_valid;
  logic          busy;
  logic          done;

  gbuff_feeder #(.ARRAY_SIZE(A), .DATA_SIZE(D), .WORD_SIZE(W), .INDX_SIZE(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .k_len(k_len),
    .gbuff_wr_en(gbuff_wr_en), .gbuff_index(gbuff_index), .gbuff_data(gbuff_data),
    .row_data(row_data), .row_valid(row_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buffer model: one-cycle read latency
  logic [W-1:0] mem [0:255];
  always @(posedge clk) gbuff_data <= mem[gbuff_index];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { int cyc; logic [W-1:0] data; logic [A-1:0] vld; } row_ev_t;
  typedef struct { int cyc; logic [IW-1:0] idx; } idx_ev_t;
  typedef struct { logic [7:0] base; logic [7:0] k; int done_off; } vec_t;

  row_ev_t rq[$];
  idx_ev_t iq[$];
  int      dq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, edge_cnt + 1);
    end
  endtask

  task automatic flag(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, edge_cnt + 1);
  endtask

  function automatic int exp_done(input int k);
    if (k == 0) return 2;
    return (SK != 0) ? k + A + 2 : k + 3;
  endfunction

  // expected index, row and done events for a job accepted at edge t
  task automatic push_job(input int t, input logic [7:0] b, input int k, input int done_off);
    row_ev_t e;
    logic [7:0] a;
    int j;
    for (int w = 0; w < k; w++) iq.push_back('{t + 1 + w, b + 8'(w)});
    if (k > 0) begin
      for (int c = t + 3; c <= t + 2 + k + SK * (A - 1); c++) begin
        e.cyc  = c;
        e.data = '0;
        e.vld  = '0;
        for (int i = 0; i < A; i++) begin
          j = c - t - 3 - SK * i;
          if (j >= 0 && j < k) begin
            a = b + 8'(j);
            e.vld[i] = 1'b1;
            e.data[8*i +: 8] = mem[a][8*i +: 8];
          end
        end
        rq.push_back(e);
      end
    end
    dq.push_back(t + done_off);
  endtask

  // called at a negedge: start is high for exactly the current cycle
  task automatic pulse(input logic [7:0] b, input logic [7:0] k, input bit acc,
                       input int done_off, output int t);
    start = 1'b1; base_addr = b; k_len = k;
    t = edge_cnt + 1;
    if (acc) push_job(t, b, int'(k), done_off);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    while (edge_cnt + 1 < c) @(negedge clk);
  endtask

  task automatic flush();
    rq.delete(); iq.delete(); dq.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((rq.size() != 0 || iq.size() != 0 || dq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      flag({nm, "_timeout"}, rq.size() + iq.size() + dq.size(), 0);
      flush();
    end
    repeat (2) @(negedge clk);
    chk({nm, "_busy_after"}, busy, 1'b0);
  endtask

  // monitor: every row/index/done is matched against the scoreboard
  int      mon_n;
  row_ev_t mon_re;
  idx_ev_t mon_ie;
  always @(negedge clk) begin
    if (rst) begin
      mon_n = edge_cnt + 1;
      if (busy) chk("wr_en", gbuff_wr_en, 1'b0);
      if (iq.size() != 0 && iq[0].cyc == mon_n) begin
        mon_ie = iq.pop_front();
        chk("index", gbuff_index, mon_ie.idx);
      end
      while (rq.size() != 0 && rq[0].cyc < mon_n) begin
        mon_re = rq.pop_front();
        flag("row_missing", mon_n, mon_re.cyc);
      end
      if (row_valid != '0) begin
        if (rq.size() == 0) flag("row_unexpected", row_valid, 0);
        else begin
          mon_re = rq.pop_front();
          chk("row_cycle", mon_n, mon_re.cyc);
          chk("row_data", row_data, mon_re.data);
          chk("row_valid", row_valid, mon_re.vld);
        end
      end else begin
        chk("zero_pad", row_data, 0);
      end
      while (dq.size() != 0 && dq[0] < mon_n) flag("done_missing", mon_n, dq.pop_front());
      if (done) begin
        if (dq.size() == 0) flag("done_unexpected", done, 0);
        else chk("done_cycle", mon_n, dq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[6];
  int   t0, t1, tx;
  logic [IW-1:0] idx_before;

  initial begin
    logic [7:0] av;
    for (int a = 0; a < 256; a++) begin
      av = a[7:0];
      mem[a] = {av ^ 8'hA5, av + 8'd3, ~av, av};
    end
    mem[8'h20] = 32'h04030201;
    mem[8'h21] = 32'h08070605;
    mem[8'h22] = 32'h0C0B0A09;

    vt[0] = '{8'h20, 8'd3, exp_done(3)};   // basic run
    vt[1] = '{8'hFE, 8'd4, exp_done(4)};   // index wrap-around
    vt[2] = '{8'h00, 8'd0, exp_done(0)};   // zero length
    vt[3] = '{8'h40, 8'd1, exp_done(1)};   // single word
    vt[4] = '{8'h80, 8'd7, exp_done(7)};
    vt[5] = '{8'hC3, 8'd2, exp_done(2)};

    rst = 1'b0; start = 1'b0; base_addr = '0; k_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", gbuff_wr_en, 1'b0);
    chk("rst_index", gbuff_index, 0);
    chk("rst_row_data", row_data, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      idx_before = gbuff_index;
      pulse(vt[v].base, vt[v].k, 1'b1, vt[v].done_off, tx);
      chk("busy_t1", busy, 1'b1);
      wait_idle("vec");
      if (vt[v].k == 8'd0) chk("zero_len_index_hold", gbuff_index, idx_before);
    end

    // second start mid-run is ignored; one done only; restart right after
    pulse(8'h50, 8'd5, 1'b1, exp_done(5), t0);
    at_cycle(t0 + 3);
    pulse(8'h60, 8'd3, 1'b0, 0, tx);
    at_cycle(t0 + 12);
    chk("busy_before_restart", busy, 1'b0);
    pulse(8'h70, 8'd2, 1'b1, exp_done(2), t1);
    chk("restart_busy", busy, 1'b1);
    wait_idle("collision");

    // reset in the middle of a long run
    pulse(8'h30, 8'd8, 1'b1, exp_done(8), tx);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    flush();
    #1;
    chk("midrst_index", gbuff_index, 0);
    chk("midrst_row_data", row_data, 0);
    chk("midrst_row_valid", row_valid, 0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse(8'h10, 8'd2, 1'b1, exp_done(2), tx);
    wait_idle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gbuff_feeder.md
# gbuff_feeder

Operand feeder between the global buffer and the systolic array. On a start pulse it streams a run of consecutive words out of the global buffer, splits each word into per-PE byte lanes and applies the diagonal skew the array needs. It zero-pads idle lanes and signals completion with a one-cycle done pulse. It is the only reader on the buffer port while busy; it never writes.

## Interface
- ARRAY_SIZE, 4, number of PE rows fed; one byte lane per row
- DATA_SIZE, 8, lane width in bits
- WORD_SIZE, 32, buffer word width; must equal ARRAY_SIZE*DATA_SIZE
- INDX_SIZE, 8, buffer index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  INDX_SIZE  first buffer index, latched on start
- k_len  in  8  number of words to stream, latched on start
- gbuff_wr_en  out  1  buffer write enable; held 0
- gbuff_index  out  INDX_SIZE  buffer read index
- gbuff_data  in  WORD_SIZE  buffer read data; valid the cycle after the index is presented
- row_data  out  ARRAY_SIZE*DATA_SIZE  skewed lanes; lane i = bits [DATA_SIZE*i +: DATA_SIZE]
- row_valid  out  ARRAY_SIZE  per-lane valid
- busy  out  1  high from the first cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse

## Operation
- Reset values: gbuff_wr_en=0, gbuff_index=0, row_data=0, row_valid=0, busy=0, done=0. All counters and the skew pipeline are cleared. The FSM returns to IDLE.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 latches base_addr and k_len and clears cnt. Next state is READ, or DONE if k_len=0.
  - READ: gbuff_index = base + cnt, then cnt++. After cnt reaches k_len-1, next state is DRAIN.
  - DRAIN: a counter waits for the read pipeline plus ARRAY_SIZE-1 skew stages to empty, then moves to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Index arithmetic is modulo 2^INDX_SIZE: base=0xFE with k_len=4 reads 0xFE, 0xFF, 0x00, 0x01.
- A 1-bit read-valid pipe tracks the buffer latency. Returned words enter the lane stage; lane i then passes through i additional registers.
- A lane with no valid word outputs data 0 and valid 0. Zero padding is required by the array.
- start while not IDLE is ignored, with no latch and no queuing.
- gbuff_index holds its last value outside READ.
- Reset mid-operation aborts immediately. No done is produced and outputs return to their reset values.

## Timing
- Let start be sampled at edge T, with K = k_len > 0 and A = ARRAY_SIZE.
- Word j index is presented in cycle T+1+j. Its data is on gbuff_data in cycle T+2+j.
- Lane i of word j appears on row_data/row_valid in cycle T+3+j+i.
- The last valid lane is at cycle T+K+A+1. done=1 in cycle T+K+A+2; busy falls the following cycle.
- k_len=0: done in cycle T+2 and no index is issued.
- Throughput is one word per cycle, with no bubbles inside a run.
- The earliest next start is accepted in the first IDLE cycle after done.

## Configuration
- FEEDER_SKEW_EN defined: diagonal skew as above; lane i is delayed i cycles.
- FEEDER_SKEW_EN undefined: no skew registers. All lanes of word j appear together in cycle T+3+j, and done occurs in cycle T+K+3. The DRAIN wait omits the A-1 skew stages.

## Test plan
- **Reset:** hold rst=0 mid-run with K=8, then release.
  - All outputs read 0 and busy=0.
  - The next start with base=0x10, K=2 runs normally.
- **Basic run (skew on):** buffer[0x20..0x22]=0x04030201, 0x08070605, 0x0C0B0A09; start base=0x20, K=3.
  - Lane0 shows 01, 05, 09 at T+3..T+5.
  - Lane3 shows 04, 08, 0C at T+6..T+8.
  - done at T+9.
- **Wrap-around:** base=0xFE, K=4.
  - gbuff_index sequence is FE, FF, 00, 01 at T+1..T+4.
  - gbuff_wr_en stays 0 throughout.
- **Zero length:** start with K=0.
  - done at T+2.
  - row_valid stays 0, and gbuff_index does not change.
- **Busy collision:** second start pulse at T+3 during a K=5 run.
  - Ignored; exactly one done at T+11.
  - A start at T+12 is accepted.
- **Macro off:** same stimulus as the basic run.
  - All four lanes are valid together: 04030201 at T+3, 08070605 at T+4, 0C0B0A09 at T+5.
  - done at T+6.
